// File: rtl/hls_kernel_sequencer_pkg.sv
// Shared types and default widths for the HLS kernel batch sequencer.
package hls_seq_pkg;

    localparam int unsigned FRAME_W_DEF   = 16;
    localparam int unsigned TIMEOUT_W_DEF = 20;
    localparam int unsigned OUTST_W       = 3;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        DRAIN = 3'd2,
        FIN   = 3'd3,
        ERR   = 3'd4
    } seq_state_e;

endpackage

// File: rtl/hls_kernel_sequencer_if.sv
// Host command/status and ap_ctrl_hs kernel handshake bundle.
interface hls_kernel_sequencer_if
    import hls_seq_pkg::*;
#(
    parameter int unsigned FRAME_W = FRAME_W_DEF
);
    logic               cmd_start;
    logic               cmd_abort;
    logic [FRAME_W-1:0] cmd_num_frames;
    logic               busy;
    logic               batch_done;
    logic               aborted;
    logic               timeout_err;
    logic [FRAME_W-1:0] frames_done;
    logic               kern_ap_start;
    logic               kern_ap_ready;
    logic               kern_ap_done;
    logic               kern_ap_idle;

    // master: host regs plus kernel side; slave: the sequencer itself
    modport master (
        output cmd_start, cmd_abort, cmd_num_frames,
        output kern_ap_ready, kern_ap_done, kern_ap_idle,
        input  busy, batch_done, aborted, timeout_err, frames_done, kern_ap_start
    );

    modport slave (
        input  cmd_start, cmd_abort, cmd_num_frames,
        input  kern_ap_ready, kern_ap_done, kern_ap_idle,
        output busy, batch_done, aborted, timeout_err, frames_done, kern_ap_start
    );
endinterface

// File: rtl/hls_kernel_sequencer_watchdog.sv
// Progress watchdog: counts enabled cycles, restarts on clear, flags expiry.
module hls_seq_watchdog
    import hls_seq_pkg::*;
#(
    parameter int unsigned TIMEOUT_W   = TIMEOUT_W_DEF,
    parameter int unsigned TIMEOUT_CYC = 1000000
) (
    input  logic clk,
    input  logic rst,
    input  logic en_i,
    input  logic clear_i,
    output logic expired_o
);
    logic [TIMEOUT_W-1:0] cnt_q;

    assign expired_o = (cnt_q == TIMEOUT_W'(TIMEOUT_CYC));

    // holds at the limit so expiry stays visible until the FSM leaves the busy states
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (clear_i || !en_i) begin
            cnt_q <= '0;
        end else if (!expired_o) begin
            cnt_q <= cnt_q + TIMEOUT_W'(1);
        end
    end
endmodule

// File: rtl/hls_kernel_sequencer.sv
// Batch sequencer for one ap_ctrl_hs kernel with overlapped starts.
// Optional progress watchdog enabled by defining HLS_SEQ_WATCHDOG_EN.
module hls_kernel_sequencer
    import hls_seq_pkg::*;
#(
    parameter int unsigned FRAME_W         = FRAME_W_DEF,
    parameter int unsigned MAX_OUTSTANDING = 2,
    parameter int unsigned TIMEOUT_W       = TIMEOUT_W_DEF,
    parameter int unsigned TIMEOUT_CYC     = 1000000
) (
    input  logic                   ap_clk,
    input  logic                   ap_rst,
    hls_kernel_sequencer_if.slave  bus
);
    localparam logic [OUTST_W-1:0] MAX_O     = OUTST_W'(MAX_OUTSTANDING);
    localparam logic [OUTST_W-1:0] OUTST_ONE = OUTST_W'(1);

    seq_state_e         state_q;
    logic [FRAME_W-1:0] n_q, issued_q, issued_d, frames_q, frames_d;
    logic [OUTST_W-1:0] outst_q, outst_d;
    logic               start_q, busy_q, batch_done_q, aborted_q;
    logic               ready_acc, done_acc, start_ok, wd_expired;
    logic               unused_cfg;

    assign unused_cfg = ^{bus.kern_ap_idle, TIMEOUT_W[0], TIMEOUT_CYC[0]};

`ifdef HLS_SEQ_WATCHDOG_EN
    seq_state_e state_prev_q;
    logic       timeout_err_q;

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) state_prev_q <= IDLE;
        else        state_prev_q <= state_q;
    end

    hls_seq_watchdog #(
        .TIMEOUT_W   (TIMEOUT_W),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_watchdog (
        .clk       (ap_clk),
        .rst       (ap_rst),
        .en_i      ((state_q == ISSUE) || (state_q == DRAIN)),
        .clear_i   (bus.kern_ap_ready || bus.kern_ap_done || (state_q != state_prev_q)),
        .expired_o (wd_expired)
    );
    assign bus.timeout_err = timeout_err_q;
`else
    assign wd_expired      = 1'b0;
    assign bus.timeout_err = 1'b0;
`endif

    // done with nothing outstanding is a kernel protocol violation and is dropped
    always_comb begin
        ready_acc = (state_q == ISSUE) && start_q && bus.kern_ap_ready;
        done_acc  = ((state_q == ISSUE) || (state_q == DRAIN)) && bus.kern_ap_done && (outst_q != '0);
        issued_d  = issued_q + FRAME_W'(ready_acc);
        frames_d  = frames_q + FRAME_W'(done_acc);
        outst_d   = outst_q;
        if (ready_acc && !done_acc)      outst_d = outst_q + OUTST_ONE;
        else if (!ready_acc && done_acc) outst_d = outst_q - OUTST_ONE;
        if ((state_q == IDLE) && bus.cmd_start) begin
            issued_d = '0;
            frames_d = '0;
            outst_d  = '0;
        end
        start_ok = (issued_d < n_q) && (outst_d < MAX_O);
    end

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            state_q      <= IDLE;
            n_q          <= '0;
            issued_q     <= '0;
            frames_q     <= '0;
            outst_q      <= '0;
            start_q      <= 1'b0;
            busy_q       <= 1'b0;
            batch_done_q <= 1'b0;
            aborted_q    <= 1'b0;
`ifdef HLS_SEQ_WATCHDOG_EN
            timeout_err_q <= 1'b0;
`endif
        end else begin
            issued_q     <= issued_d;
            frames_q     <= frames_d;
            outst_q      <= outst_d;
            start_q      <= 1'b0;
            busy_q       <= 1'b0;
            batch_done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.cmd_start) begin
                        n_q       <= bus.cmd_num_frames;
                        aborted_q <= 1'b0;
`ifdef HLS_SEQ_WATCHDOG_EN
                        timeout_err_q <= 1'b0;
`endif
                        if (bus.cmd_num_frames == '0) begin
                            state_q      <= FIN;
                            batch_done_q <= 1'b1;
                        end else begin
                            state_q <= ISSUE;
                            busy_q  <= 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    if (wd_expired) begin
                        state_q      <= ERR;
                        batch_done_q <= 1'b1;
`ifdef HLS_SEQ_WATCHDOG_EN
                        timeout_err_q <= 1'b1;
`endif
                    end else if (bus.cmd_abort || (issued_d == n_q)) begin
                        state_q <= DRAIN;
                        busy_q  <= 1'b1;
                        if (bus.cmd_abort) aborted_q <= 1'b1;
                    end else begin
                        busy_q  <= 1'b1;
                        start_q <= start_ok;
                    end
                end
                DRAIN: begin
                    if (wd_expired) begin
                        state_q      <= ERR;
                        batch_done_q <= 1'b1;
`ifdef HLS_SEQ_WATCHDOG_EN
                        timeout_err_q <= 1'b1;
`endif
                    end else if (outst_d == '0) begin
                        state_q      <= FIN;
                        batch_done_q <= 1'b1;
                    end else begin
                        busy_q <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.busy          = busy_q;
    assign bus.batch_done    = batch_done_q;
    assign bus.aborted       = aborted_q;
    assign bus.frames_done   = frames_q;
    assign bus.kern_ap_start = start_q;
endmodule

// File: tb/tb_hls_kernel_sequencer.sv
// Directed bench: two sequencers (MAX_OUTSTANDING 1 and 2) driven by one host, each with a kernel model.
module tb_hls_kernel_sequencer;
    localparam int FW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          cmd_start = 1'b0;
    logic          cmd_abort = 1'b0;
    logic [FW-1:0] cmd_num = '0;
    logic          tb_clr = 1'b0;
    int            kr = 1;
    int            kl = 5;
    int            n_tb = 0;
    int            passed = 0;
    int            total = 0;

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
        localparam int MAXV = gi + 1;
        hls_kernel_sequencer_if #(.FRAME_W(FW)) bus ();
        int   acc_cnt = 0, dn_cnt = 0, bd_cnt = 0, coinc = 0, maxo = 0, viol = 0;
        logic start_seen = 1'b0, busy_seen = 1'b0;
        int   cyc = 0, wcnt = 0;
        int   due_q[$];

        hls_kernel_sequencer #(
            .FRAME_W         (FW),
            .MAX_OUTSTANDING (MAXV),
            .TIMEOUT_W       (20),
            .TIMEOUT_CYC     (50)
        ) dut (
            .ap_clk (clk),
            .ap_rst (rst),
            .bus    (bus.slave)
        );

        assign bus.cmd_start      = cmd_start;
        assign bus.cmd_abort      = cmd_abort;
        assign bus.cmd_num_frames = cmd_num;
        assign bus.kern_ap_idle   = (acc_cnt == dn_cnt);

        // kernel: ready after kr cycles of start, done kl cycles after acceptance
        always @(posedge clk) begin
            cyc <= cyc + 1;
            if (rst) begin
                bus.kern_ap_ready <= 1'b0;
                bus.kern_ap_done  <= 1'b0;
                wcnt <= 0;
                due_q.delete();
            end else begin
                bus.kern_ap_ready <= 1'b0;
                bus.kern_ap_done  <= 1'b0;
                if (bus.kern_ap_start && bus.kern_ap_ready) begin
                    due_q.push_back(cyc + kl);
                    wcnt <= 0;
                end else if (bus.kern_ap_start) begin
                    if (wcnt + 1 >= kr) begin
                        bus.kern_ap_ready <= 1'b1;
                        wcnt <= 0;
                    end else begin
                        wcnt <= wcnt + 1;
                    end
                end else begin
                    wcnt <= 0;
                end
                if (due_q.size() > 0 && due_q[0] == cyc) begin
                    bus.kern_ap_done <= 1'b1;
                    void'(due_q.pop_front());
                end
            end
        end

        // handshake tallies; viol counts start asserted when no start is allowed
        always @(posedge clk) begin
            if (tb_clr) begin
                acc_cnt <= 0; dn_cnt <= 0; bd_cnt <= 0; coinc <= 0; maxo <= 0; viol <= 0;
                start_seen <= 1'b0; busy_seen <= 1'b0;
            end else begin
                if (bus.kern_ap_start && bus.kern_ap_ready) acc_cnt <= acc_cnt + 1;
                if (bus.kern_ap_done) dn_cnt <= dn_cnt + 1;
                if (bus.batch_done) bd_cnt <= bd_cnt + 1;
                if (bus.kern_ap_start) start_seen <= 1'b1;
                if (bus.busy) busy_seen <= 1'b1;
                if (bus.kern_ap_start && bus.kern_ap_ready && bus.kern_ap_done) coinc <= coinc + 1;
                if (acc_cnt - dn_cnt > maxo) maxo <= acc_cnt - dn_cnt;
                if (bus.kern_ap_start && ((acc_cnt - dn_cnt) >= MAXV || acc_cnt >= n_tb)) viol <= viol + 1;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
            $display("check %s: observed %0d expected %0d ok", tag, obs, exp);
        end else begin
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic run(input int n);
        @(negedge clk);
        tb_clr = 1'b1;
        n_tb   = n;
        @(negedge clk);
        tb_clr    = 1'b0;
        cmd_num   = FW'(n);
        cmd_start = 1'b1;
        @(negedge clk);
        cmd_start = 1'b0;
    endtask

    task automatic wait_end(input string tag, input int limit);
        int k = 0;
        while (k < limit && !(g_dut[0].bd_cnt > 0 && g_dut[1].bd_cnt > 0)) begin
            @(negedge clk);
            k++;
        end
        chk(tag, 32'(k < limit), 32'd1);
    endtask

    initial begin
        int k;
        #1 rst = 1'b1;
        #20;
        chk("rst_start",       32'(g_dut[1].bus.kern_ap_start), 32'd0);
        chk("rst_busy",        32'(g_dut[1].bus.busy),          32'd0);
        chk("rst_batch_done",  32'(g_dut[1].bus.batch_done),    32'd0);
        chk("rst_aborted",     32'(g_dut[1].bus.aborted),       32'd0);
        chk("rst_frames",      32'(g_dut[1].bus.frames_done),   32'd0);
        chk("rst_timeout_err", 32'(g_dut[1].bus.timeout_err),   32'd0);
        @(negedge clk);
        rst = 1'b0;

        // N=3 on the MAX=1 sequencer
        kr = 1; kl = 5;
        run(3);
        wait_end("t1_end", 300);
        repeat (4) @(negedge clk);
        chk("t1_accepts",    32'(g_dut[0].acc_cnt),         32'd3);
        chk("t1_dones",      32'(g_dut[0].dn_cnt),          32'd3);
        chk("t1_frames",     32'(g_dut[0].bus.frames_done), 32'd3);
        chk("t1_batch_done", 32'(g_dut[0].bd_cnt),          32'd1);
        chk("t1_max_outst",  32'(g_dut[0].maxo),            32'd1);
        chk("t1_start_rule", 32'(g_dut[0].viol),            32'd0);
        chk("t1_busy",       32'(g_dut[0].bus.busy),        32'd0);

        // N=4 on MAX=2, ready and done coincide
        kr = 1; kl = 10;
        run(4);
        wait_end("t2_end", 300);
        repeat (4) @(negedge clk);
        chk("t2_accepts",    32'(g_dut[1].acc_cnt),         32'd4);
        chk("t2_frames",     32'(g_dut[1].bus.frames_done), 32'd4);
        chk("t2_max_outst",  32'(g_dut[1].maxo),            32'd2);
        chk("t2_coincident", 32'(g_dut[1].coinc != 0),      32'd1);
        chk("t2_start_rule", 32'(g_dut[1].viol),            32'd0);
        chk("t2_batch_done", 32'(g_dut[1].bd_cnt),          32'd1);

        // N=5 aborted after the second acceptance
        kr = 1; kl = 10;
        run(5);
        k = 0;
        while (k < 100 && g_dut[1].acc_cnt != 2) begin
            @(negedge clk);
            k++;
        end
        chk("t4_second_ready", 32'(g_dut[1].acc_cnt), 32'd2);
        cmd_abort = 1'b1;
        @(negedge clk);
        cmd_abort = 1'b0;
        chk("t4_start_low",  32'(g_dut[1].bus.kern_ap_start), 32'd0);
        chk("t4_draining",   32'(g_dut[1].bus.busy),          32'd1);
        wait_end("t4_end", 300);
        repeat (4) @(negedge clk);
        chk("t4_aborted",    32'(g_dut[1].bus.aborted),       32'd1);
        chk("t4_frames",     32'(g_dut[1].bus.frames_done),   32'd2);
        chk("t4_accepts",    32'(g_dut[1].acc_cnt),           32'd2);
        chk("t4_batch_done", 32'(g_dut[1].bd_cnt),            32'd1);

        // N=0: FIN right after the accepting edge, no start, no busy
        run(0);
        chk("t3_batch_done_hi", 32'(g_dut[1].bus.batch_done),  32'd1);
        chk("t3_busy",          32'(g_dut[1].bus.busy),        32'd0);
        chk("t3_aborted_clr",   32'(g_dut[1].bus.aborted),     32'd0);
        chk("t3_frames_clr",    32'(g_dut[1].bus.frames_done), 32'd0);
        @(negedge clk);
        chk("t3_batch_done_lo", 32'(g_dut[1].bus.batch_done),  32'd0);
        repeat (3) @(negedge clk);
        chk("t3_start_seen",    32'(g_dut[1].start_seen),      32'd0);
        chk("t3_busy_seen",     32'(g_dut[1].busy_seen),       32'd0);
        chk("t3_bd_count",      32'(g_dut[1].bd_cnt),          32'd1);

        // async reset while start is held, then a clean batch
        kr = 4; kl = 5;
        run(3);
        k = 0;
        while (k < 20 && g_dut[1].bus.kern_ap_start !== 1'b1) begin
            @(negedge clk);
            k++;
        end
        chk("t5_start_up", 32'(g_dut[1].bus.kern_ap_start), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("t5_rst_start", 32'(g_dut[1].bus.kern_ap_start), 32'd0);
        chk("t5_rst_busy",  32'(g_dut[1].bus.busy),          32'd0);
        @(negedge clk);
        rst = 1'b0;
        kr = 1;
        run(2);
        wait_end("t5_end", 300);
        repeat (4) @(negedge clk);
        chk("t5_accepts",    32'(g_dut[1].acc_cnt),         32'd2);
        chk("t5_frames",     32'(g_dut[1].bus.frames_done), 32'd2);
        chk("t5_batch_done", 32'(g_dut[1].bd_cnt),          32'd1);
        chk("t5_aborted",    32'(g_dut[1].bus.aborted),     32'd0);

`ifdef HLS_SEQ_WATCHDOG_EN
        // kernel never readies: watchdog fires at TIMEOUT_CYC
        kr = 1000000;
        run(2);
        repeat (45) @(negedge clk);
        chk("t6_not_early", 32'(g_dut[1].bus.timeout_err),   32'd0);
        chk("t6_start_held", 32'(g_dut[1].bus.kern_ap_start), 32'd1);
        k = 0;
        while (k < 20 && g_dut[1].bus.timeout_err !== 1'b1) begin
            @(negedge clk);
            k++;
        end
        chk("t6_timeout_err", 32'(g_dut[1].bus.timeout_err),   32'd1);
        chk("t6_batch_done",  32'(g_dut[1].bus.batch_done),    32'd1);
        chk("t6_start_low",   32'(g_dut[1].bus.kern_ap_start), 32'd0);
        repeat (3) @(negedge clk);
        chk("t6_bd_count",    32'(g_dut[1].bd_cnt),            32'd1);
        chk("t6_sticky",      32'(g_dut[1].bus.timeout_err),   32'd1);
        kr = 1;
        run(0);
        chk("t6_cleared",     32'(g_dut[1].bus.timeout_err),   32'd0);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
